// File: rtl/timer_pkg.sv
// Shared types and limits for the countdown timer.
// Time fields are binary minutes/seconds, 0..59.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  typedef logic [5:0] tfield_t;

  localparam tfield_t MAX_SEC = 6'd59;
  localparam tfield_t MAX_MIN = 6'd59;

  function automatic tfield_t sat(
    input tfield_t v,
    input tfield_t lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle TICK every TICK_DIV enabled cycles.
// Counter is cleared whenever EN is low.
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  output logic TICK
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (!EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/timer_core.sv
// MM:SS countdown timer with pause, preset load and alarm.
// Priority per cycle: LOAD > STOP > START > tick.
module timer_core
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       LOAD,
  input  logic [5:0] SET_MIN,
  input  logic [5:0] SET_SEC,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM
);

  state_t  state_q, state_d;
  tfield_t min_q, min_d;
  tfield_t sec_q, sec_d;
  logic    done_d;
  logic    tick;
  logic    tick_en;
  logic    nonzero;

  // STOP gates the prescaler so a coincident tick is dropped
  assign tick_en = (state_q == RUN) && !STOP;
  assign nonzero = (min_q != '0) || (sec_q != '0);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (tick_en),
    .TICK (tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (LOAD) begin
          min_d   = sat(SET_MIN, MAX_MIN);
          sec_d   = sat(SET_SEC, MAX_SEC);
          state_d = IDLE;
        end else if (STOP) begin
          state_d = state_q;
        end else if (START && nonzero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (sec_q != '0) begin
            sec_d = sec_q - 6'd1;
            if (min_q == '0 && sec_q == 6'd1) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end else if (min_q != '0) begin
            min_d = min_q - 6'd1;
            sec_d = MAX_SEC;
          end
        end
      end
      EXPIRED: begin
        if (LOAD) begin
          min_d   = sat(SET_MIN, MAX_MIN);
          sec_d   = sat(SET_SEC, MAX_SEC);
          state_d = IDLE;
        end else if (STOP) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
      ALARM   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      RUNNING <= (state_d == RUN);
      DONE    <= done_d;
      ALARM   <= (state_d == EXPIRED);
    end
  end

  assign MIN = min_q;
  assign SEC = sec_q;

endmodule

// File: tb/tb_timer_core.sv
// Directed and random stimulus for timer_core (TICK_DIV=4)
// against a remaining-seconds reference model.
module tb_timer_core;

  localparam int TD = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START, STOP, LOAD;
  logic [5:0] SET_MIN, SET_SEC;
  logic [5:0] MIN, SEC;
  logic       RUNNING, DONE, ALARM;

  int checks = 0;
  int failures = 0;

  // model: mode 0=idle 1=run 2=pause 3=expired
  int  rem;
  int  md;
  int  ph;
  bit  mdone;

  timer_core #(.TICK_DIV(TD)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .STOP   (STOP),
    .LOAD   (LOAD),
    .SET_MIN(SET_MIN),
    .SET_SEC(SET_SEC),
    .MIN    (MIN),
    .SEC    (SEC),
    .RUNNING(RUNNING),
    .DONE   (DONE),
    .ALARM  (ALARM)
  );

  always #5 CLK = ~CLK;

  function automatic int sat59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"}, int'(MIN), rem / 60);
    chk({tag, ".sec"}, int'(SEC), rem % 60);
    chk({tag, ".running"}, int'(RUNNING), (md == 1) ? 1 : 0);
    chk({tag, ".alarm"}, int'(ALARM), (md == 3) ? 1 : 0);
    chk({tag, ".done"}, int'(DONE), mdone ? 1 : 0);
  endtask

  task automatic model_reset();
    rem = 0;
    md = 0;
    ph = 0;
    mdone = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit ld,
                            input int m, input int s);
    mdone = 0;
    if (md == 1) begin
      if (sp) begin
        md = 2;
      end else begin
        ph++;
        if (ph == TD) begin
          ph = 0;
          rem--;
          if (rem == 0) begin
            md = 3;
            mdone = 1;
          end
        end
      end
    end else if (ld) begin
      rem = sat59(m) * 60 + sat59(s);
      md = 0;
    end else if (sp) begin
      if (md == 3) md = 0;
    end else if (st && rem != 0 && md != 3) begin
      md = 1;
      ph = 0;
    end
  endtask

  task automatic cyc(input string tag, input bit st, input bit sp,
                     input bit ld, input int m, input int s);
    START = st;
    STOP = sp;
    LOAD = ld;
    SET_MIN = 6'(m);
    SET_SEC = 6'(s);
    @(posedge CLK);
    model_step(st, sp, ld, m, s);
    #1;
    START = 0;
    STOP = 0;
    LOAD = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RST_N = 0;
    START = 0;
    STOP = 0;
    LOAD = 0;
    SET_MIN = 0;
    SET_SEC = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1;
    idle("post_rst", 2);

    // 00:03 countdown to expiry
    cyc("load3", 0, 0, 1, 0, 3);
    cyc("start3", 1, 0, 0, 0, 0);
    idle("count3", 14);
    chk("expired.alarm", int'(ALARM), 1);
    idle("hold_exp", 3);

    // 01:00 borrow, pause, resume
    cyc("load100", 0, 0, 1, 1, 0);
    cyc("start100", 1, 0, 0, 0, 0);
    idle("borrow", 4);
    chk("borrow.sec", int'(SEC), 59);
    cyc("pause", 0, 1, 0, 0, 0);
    idle("frozen", 20);
    cyc("resume", 1, 0, 0, 0, 0);
    idle("resumed", 6);
    cyc("pause2", 0, 1, 0, 0, 0);

    // saturation and zero start
    cyc("sat", 0, 0, 1, 63, 60);
    cyc("load0", 0, 0, 1, 0, 0);
    cyc("start0", 1, 0, 0, 0, 0);
    idle("zero_idle", 3);

    // load+start together, stop on tick
    cyc("ld_st", 1, 0, 1, 2, 10);
    idle("ld_st_idle", 2);
    cyc("start", 1, 0, 0, 0, 0);
    idle("pre_tick", 3);
    cyc("stop_tick", 0, 1, 0, 0, 0);
    idle("after_stop", 5);

    // expired handling
    cyc("load1", 0, 0, 1, 0, 1);
    cyc("start1", 1, 0, 0, 0, 0);
    idle("to_exp", 5);
    cyc("exp_start", 1, 0, 0, 0, 0);
    cyc("exp_load_run", 0, 0, 0, 0, 0);
    cyc("exp_stop", 0, 1, 0, 0, 0);

    // async reset mid-run
    cyc("load5", 0, 0, 1, 0, 5);
    cyc("start5", 1, 0, 0, 0, 0);
    idle("run5", 6);
    #2;
    RST_N = 0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (3) begin
      @(posedge CLK);
      #1;
      check_all("in_rst");
    end
    @(negedge CLK);
    RST_N = 1;
    idle("rel", 3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st, sp, ld;
      int m, s;
      st = ($urandom_range(0, 99) < 15);
      sp = ($urandom_range(0, 99) < 5);
      ld = ($urandom_range(0, 99) < 6);
      m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4));
      cyc("rand", st, sp, ld, m, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_core.md
TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 Parameter TICK_DIV, default 100000000, CLK cycles per 1 s countdown tick (>=2).
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 START  input  1  single-cycle start/resume request.
REQ-005 STOP  input  1  single-cycle pause / alarm-acknowledge request.
REQ-006 LOAD  input  1  single-cycle preset load strobe.
REQ-007 SET_MIN  input  6  preset minutes, binary.
REQ-008 SET_SEC  input  6  preset seconds, binary.
REQ-009 MIN  output  6  current minutes, binary 0..59; feeds the binary-to-BCD converter.
REQ-010 SEC  output  6  current seconds, binary 0..59; feeds the binary-to-BCD converter.
REQ-011 RUNNING  output  1  high while in state RUN.
REQ-012 DONE  output  1  one-cycle pulse on expiry.
REQ-013 ALARM  output  1  high while in state EXPIRED.

Function
REQ-014 States SHALL be IDLE, RUN, PAUSE, EXPIRED; all outputs registered.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick asserted for one cycle when count = TICK_DIV-1, then wraps to 0.
REQ-016 Prescaler SHALL be held at 0 in every state other than RUN, so a resumed run waits a full TICK_DIV before its first tick.
REQ-017 On tick with SEC>0: SEC <= SEC-1, MIN unchanged.
REQ-018 On tick with SEC=0, MIN>0: MIN <= MIN-1, SEC <= 59.
REQ-019 On tick that produces 00:00: state SHALL go to EXPIRED in the same edge; DONE high the following cycle only.
REQ-020 LOAD SHALL be accepted in IDLE, PAUSE, EXPIRED; MIN/SEC updated next edge; state becomes IDLE.
REQ-021 LOAD inputs >59 SHALL be saturated to 59 per field.
REQ-022 LOAD in RUN SHALL be ignored.
REQ-023 START in IDLE or PAUSE SHALL enter RUN only if MIN:SEC != 00:00; otherwise ignored.
REQ-024 START in RUN or EXPIRED SHALL be ignored.
REQ-025 STOP in RUN -> PAUSE, value held; STOP in EXPIRED -> IDLE (ALARM cleared), value stays 00:00; STOP in IDLE/PAUSE ignored.
REQ-026 Priority within a cycle: LOAD > STOP > START; in RUN, STOP beats a coincident tick (tick discarded, no decrement).
REQ-027 Counting SHALL never wrap below 00:00 or exceed 59:59.

Reset
REQ-028 RST_N low SHALL asynchronously force state IDLE, prescaler 0, MIN=0, SEC=0, RUNNING=0, DONE=0, ALARM=0.
REQ-029 Reset asserted mid-RUN SHALL abort the run with no DONE pulse; release SHALL be synchronous to CLK with no action until next request.

Structure
REQ-030 Package timer_pkg SHALL hold the state enum, MAX_SEC=59, MAX_MIN=59 and the 6-bit time field type.
REQ-031 Prescaler SHALL be a sub-module tick_gen (inputs CLK, RST_N, EN; output TICK), parameterised by TICK_DIV.
REQ-032 Implementation SHALL fit 120-400 lines total.

Verification (TICK_DIV=4)
REQ-033 Reset then LOAD 00:03, START -> SEC 3,2,1,0 at 4-cycle intervals; DONE one cycle; ALARM=1; RUNNING=0.
REQ-034 LOAD 01:00, START, one tick -> MIN=0, SEC=59; STOP -> PAUSE, value frozen 20 cycles; START -> first decrement 4 cycles later.
REQ-035 LOAD SET_MIN=63, SET_SEC=60 -> MIN=59, SEC=59; START with 00:00 loaded -> RUNNING stays 0.
REQ-036 LOAD+START same cycle in IDLE -> value loaded, state IDLE; STOP coincident with tick in RUN -> no decrement, PAUSE.
REQ-037 In EXPIRED: START ignored, STOP -> IDLE, ALARM=0; RST_N low mid-RUN -> all outputs 0 immediately, no DONE.
